// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with boot hold-off, delay-slot redirects and a sticky fetch-fault halt
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          IM_WORDS    = 4096,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [2:0]  d_npc_sel,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [15:0] d_imm16,
    input  logic [31:0] d_rs_val,
    input  logic        d_cmp_true,
    output logic [31:0] F_PC,
    output logic        f_valid,
    output logic        redirect,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [32:0] PC_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);
    state_t      r_state, w_state;
    logic [3:0]  r_boot_cnt, w_boot_cnt;
    logic [31:0] r_pc, w_pc, w_pc_plus4, w_target, r_fault_pc, w_fault_pc;
    logic [15:0] r_stall_cnt, w_stall_cnt;
    logic        r_redirect, w_redirect, w_nonseq, w_bad, r_fault, w_fault;
    always_comb begin
        w_pc_plus4  = d_pc + 32'd4;
        w_nonseq    = d_valid && (d_npc_sel == 3'b001 || d_npc_sel == 3'b010 || (d_npc_sel == 3'b011 && d_cmp_true));
        w_target    = !w_nonseq ? r_pc + 32'd4 :
                      d_npc_sel == 3'b001 ? {w_pc_plus4[31:28], d_imm26, 2'b00} :
                      d_npc_sel == 3'b010 ? d_rs_val :
                      w_pc_plus4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
        w_bad       = |w_target[1:0] || w_target < RESET_PC || {1'b0, w_target} >= PC_END;
        w_state     = r_state;
        w_boot_cnt  = r_boot_cnt;
        w_pc        = r_pc;
        w_redirect  = 1'b0;
        w_fault     = r_fault;
        w_fault_pc  = r_fault_pc;
        w_stall_cnt = r_stall_cnt;
        if (r_state == BOOT) begin
            w_boot_cnt = r_boot_cnt + 4'd1;
            w_state    = r_boot_cnt == 4'(BOOT_CYCLES - 1) ? RUN : BOOT;
        end else if (r_state == RUN && stall) begin
            w_stall_cnt = r_stall_cnt + {15'd0, r_stall_cnt != 16'hFFFF};
        end else if (r_state == RUN) begin
            w_pc       = w_target;
            w_redirect = w_nonseq;
            w_fault    = w_bad;
            w_fault_pc = w_bad ? w_target : r_fault_pc;
            w_state    = w_bad ? HALT : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BOOT;
            r_boot_cnt  <= 4'd0;
            r_pc        <= RESET_PC;
            r_redirect  <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_pc  <= 32'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state     <= w_state;
            r_boot_cnt  <= w_boot_cnt;
            r_pc        <= w_pc;
            r_redirect  <= w_redirect;
            r_fault     <= w_fault;
            r_fault_pc  <= w_fault_pc;
            r_stall_cnt <= w_stall_cnt;
        end
    end
    assign F_PC      = r_pc;
    assign f_valid   = r_state == RUN;
    assign redirect  = r_redirect;
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
    localparam logic [31:0] RST = 32'h0000_3000;
    localparam int WORDS = 4096;
    localparam int BOOT = 2;
    logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, d_valid = 1'b0, d_cmp_true = 1'b0;
    logic [2:0]  d_npc_sel = 3'd0;
    logic [31:0] d_pc = 32'd0, d_rs_val = 32'd0;
    logic [25:0] d_imm26 = 26'd0;
    logic [15:0] d_imm16 = 16'd0;
    logic [31:0] F_PC, fault_pc;
    logic        f_valid, redirect, fault;
    logic [15:0] stall_cnt;
    int          n_tests = 0, n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc, m_fpc;
    int          m_boot;
    bit          m_halt, m_fault, m_redir;
    logic [15:0] m_scnt;

    pc_sequencer #(.RESET_PC(RST), .IM_WORDS(WORDS), .BOOT_CYCLES(BOOT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .d_npc_sel(d_npc_sel),
        .d_pc(d_pc), .d_imm26(d_imm26), .d_imm16(d_imm16), .d_rs_val(d_rs_val),
        .d_cmp_true(d_cmp_true), .F_PC(F_PC), .f_valid(f_valid), .redirect(redirect),
        .fault(fault), .fault_pc(fault_pc), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit illegal(input logic [31:0] t);
        return t % 4 != 0 || t < RST || 64'(t) >= 64'(RST) + 64'(4 * WORDS);
    endfunction

    task automatic model_step();
        logic [31:0] t;
        bit nonseq;
        if (reset) begin
            m_pc = RST; m_boot = BOOT; m_halt = 0; m_fault = 0; m_fpc = 0; m_redir = 0; m_scnt = 0;
        end else if (m_boot > 0) begin
            m_boot--; m_redir = 0;
        end else if (m_halt) begin
            m_redir = 0;
        end else if (stall) begin
            m_redir = 0;
            if (m_scnt != 16'hFFFF) m_scnt++;
        end else begin
            nonseq = d_valid && (d_npc_sel == 1 || d_npc_sel == 2 || (d_npc_sel == 3 && d_cmp_true));
            if (!nonseq) t = m_pc + 4;
            else if (d_npc_sel == 1) t = ((d_pc + 4) & 32'hF000_0000) | (32'(d_imm26) * 4);
            else if (d_npc_sel == 2) t = d_rs_val;
            else t = d_pc + 4 + 32'($signed(d_imm16) * 4);
            m_pc = t; m_redir = nonseq;
            if (illegal(t)) begin m_fault = 1; m_fpc = t; m_halt = 1; end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        chk_en = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [2:0] sel, input logic [31:0] pc, input logic [25:0] i26,
                         input logic [15:0] i16, input logic [31:0] rs, input bit cmp);
        d_valid = v; d_npc_sel = sel; d_pc = pc; d_imm26 = i26; d_imm16 = i16; d_rs_val = rs; d_cmp_true = cmp;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc", F_PC, m_pc);
            chk("model_fvalid", 32'(f_valid), 32'(m_boot == 0 && !m_halt));
            chk("model_redirect", 32'(redirect), 32'(m_redir));
            chk("model_fault", 32'(fault), 32'(m_fault));
            chk("model_fault_pc", fault_pc, m_fpc);
            chk("model_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        end
    end

    initial begin
        reset = 1; cyc(); reset = 0;
        chk("reset_pc", F_PC, 32'h3000); chk("reset_fvalid", 32'(f_valid), 0);
        chk("reset_fault", 32'(fault), 0); chk("reset_scnt", 32'(stall_cnt), 0);
        cyc(); chk("boot2_fvalid", 32'(f_valid), 0); chk("boot2_pc", F_PC, 32'h3000);
        cyc(); chk("run_fvalid", 32'(f_valid), 1); chk("run_pc0", F_PC, 32'h3000);
        cyc(); chk("seq_pc1", F_PC, 32'h3004);
        cyc(); chk("seq_pc2", F_PC, 32'h3008);
        drive(1, 3'b011, 32'h3004, 0, 16'hFFFF, 0, 1);
        cyc(); chk("br_taken_pc", F_PC, 32'h3004); chk("br_taken_redir", 32'(redirect), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); chk("br_pulse_end", 32'(redirect), 0); chk("br_seq", F_PC, 32'h3008);
        drive(1, 3'b011, 32'h3004, 0, 16'hFFFF, 0, 0);
        cyc(); chk("br_nt_pc", F_PC, 32'h300C); chk("br_nt_redir", 32'(redirect), 0);
        drive(1, 3'b001, 32'h3010, 26'h0000C10, 0, 0, 0);
        cyc(); chk("j_pc", F_PC, 32'h3040); chk("j_redir", 32'(redirect), 1);
        drive(1, 3'b010, 32'h3040, 0, 0, 32'h3100, 0);
        cyc(); chk("jr_pc", F_PC, 32'h3100);
        drive(1, 3'b011, 32'h3100, 0, 16'h0010, 0, 1);
        stall = 1;
        repeat (3) cyc();
        chk("stall_pc", F_PC, 32'h3100); chk("stall_cnt3", 32'(stall_cnt), 3); chk("stall_redir", 32'(redirect), 0);
        stall = 0;
        cyc(); chk("unstall_pc", F_PC, 32'h3144); chk("unstall_redir", 32'(redirect), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); chk("after_br_seq", F_PC, 32'h3148);
        drive(1, 3'b101, 32'h3144, 26'h3FFFFFF, 16'h8000, 32'h5000, 1);
        cyc(); chk("reserved_pc", F_PC, 32'h314C); chk("reserved_redir", 32'(redirect), 0);
        drive(1, 3'b010, 32'h3148, 0, 0, 32'h3102, 0);
        cyc(); chk("mis_fault", 32'(fault), 1); chk("mis_fault_pc", fault_pc, 32'h3102);
        chk("mis_fvalid", 32'(f_valid), 0); chk("mis_pc", F_PC, 32'h3102);
        drive(1, 3'b010, 32'h3148, 0, 0, 32'h3200, 0);
        cyc(); cyc(); chk("halt_pc", F_PC, 32'h3102); chk("halt_fault", 32'(fault), 1); chk("halt_redir", 32'(redirect), 0);
        reset = 1; cyc(); reset = 0;
        chk("rst2_pc", F_PC, 32'h3000); chk("rst2_fault", 32'(fault), 0); chk("rst2_fpc", fault_pc, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        drive(1, 3'b010, 32'h2FFC, 0, 0, 32'h6FF8, 0);
        cyc(); chk("end_jr", F_PC, 32'h6FF8);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc(); chk("end_last", F_PC, 32'h6FFC); chk("end_last_ok", 32'(fault), 0);
        cyc(); chk("wrap_fault", 32'(fault), 1); chk("wrap_fpc", fault_pc, 32'h7000); chk("wrap_fvalid", 32'(f_valid), 0);
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 63) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            stall = $urandom_range(0, 3) == 0;
            d_valid = $urandom_range(0, 4) != 0;
            d_npc_sel = 3'($urandom_range(0, 7));
            d_pc = $urandom_range(0, 15) == 0 ? $urandom() : m_pc - 4;
            d_imm26 = $urandom_range(0, 7) == 0 ? 26'($urandom()) : 26'(32'hC00 + $urandom_range(0, WORDS - 1));
            d_imm16 = 16'($signed($urandom_range(0, 200)) - 100);
            d_rs_val = $urandom_range(0, 7) == 0 ? $urandom() : RST + 4 * $urandom_range(0, WORDS - 1) + 32'($urandom_range(0, 9) == 0);
            d_cmp_true = $urandom_range(0, 1) == 1;
            cyc();
        end
        reset = 0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
